// File: rtl/section_writer_n_pkg.sv
// Shared types for the section writer: the two sections the output FSM alternates between.
package section_writer_n_types;

    typedef enum logic {
        SECTION_A = 1'b0,
        SECTION_B = 1'b1
    } SECTIONS;

endpackage

// File: rtl/section_writer_n_out_port_reg.sv
// One output port: a data register with a valid (notify) flag.
// load captures new data and raises notify; clear drops notify but keeps the data.
module out_port_reg #(
    parameter int             W          = 32,
    parameter logic [W-1:0]   RST_DATA   = '0,
    parameter logic           RST_NOTIFY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         notify
);

    logic [W-1:0] data_q, data_d;
    logic         notify_q, notify_d;

    always_comb begin
        data_d   = data_q;
        notify_d = notify_q;
        if (load) begin
            data_d   = load_data;
            notify_d = 1'b1;
        end else if (clear) begin
            notify_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= RST_DATA;
            notify_q <= RST_NOTIFY;
        end else begin
            data_q   <= data_d;
            notify_q <= notify_d;
        end
    end

    assign data   = data_q;
    assign notify = notify_q;

endmodule

// File: rtl/section_writer_n.sv
// Round-robin writer: the unsigned counter goes to channels 0..N-1 in turn, then the
// signed counter goes to b_out2, repeating. Exactly one notify is high at any time.
module section_writer_n
    import section_writer_n_types::*;
#(
    parameter int           W      = 32,
    parameter int           N      = 2,
    parameter int           STEP   = 1,
    parameter logic [W-1:0] INIT_U = 13,
    parameter int           INIT_S = -7
) (
    input  logic           clk,
    input  logic           rst,
    output logic [N*W-1:0] b_out,
    input  logic [N-1:0]   b_out_sync,
    output logic [N-1:0]   b_out_notify,
    output logic [W-1:0]   b_out2,
    input  logic           b_out2_sync,
    output logic           b_out2_notify
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    SECTIONS       sec_q, sec_d;
    logic [W-1:0]  val_u_q, val_u_d;
    logic [W-1:0]  val_s_q, val_s_d;
    logic [CW-1:0] ch_q, ch_d;

    logic [N-1:0]  ld_u, clr_u;
    logic          ld_s, clr_s;
    logic [W-1:0]  u_data;
    logic          xfer_a, xfer_b;
    logic [CW-1:0] nxt_ch;

    // Only the notified port can complete a transfer; stray syncs are masked off.
    assign xfer_a = |(b_out_notify & b_out_sync);
    assign xfer_b = b_out2_notify & b_out2_sync;
    assign nxt_ch = ch_q + CW'(1);

    always_comb begin
        sec_d   = sec_q;
        val_u_d = val_u_q;
        val_s_d = val_s_q;
        ch_d    = ch_q;
        ld_u    = '0;
        clr_u   = '0;
        ld_s    = 1'b0;
        clr_s   = 1'b0;
        u_data  = val_u_q;
        case (sec_q)
            SECTION_A: begin
                if (xfer_a) begin
                    val_u_d = val_u_q + W'(STEP);
                    u_data  = val_u_d;
                    for (int i = 0; i < N; i++) begin
                        clr_u[i] = (ch_q == CW'(i));
                    end
                    if (ch_q == CW'(N - 1)) begin
                        ld_s  = 1'b1;
                        sec_d = SECTION_B;
                    end else begin
                        ch_d = nxt_ch;
                        for (int i = 0; i < N; i++) begin
                            ld_u[i] = (nxt_ch == CW'(i));
                        end
                    end
                end
            end
            SECTION_B: begin
                // Channel 0 restarts with the value already advanced by the last A transfer.
                if (xfer_b) begin
                    val_s_d  = val_s_q - W'(STEP);
                    clr_s    = 1'b1;
                    ch_d     = '0;
                    ld_u[0]  = 1'b1;
                    sec_d    = SECTION_A;
                end
            end
            default: sec_d = SECTION_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q   <= SECTION_A;
            val_u_q <= INIT_U;
            val_s_q <= W'(INIT_S);
            ch_q    <= '0;
        end else begin
            sec_q   <= sec_d;
            val_u_q <= val_u_d;
            val_s_q <= val_s_d;
            ch_q    <= ch_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            out_port_reg #(
                .W          (W),
                .RST_DATA   ((gi == 0) ? INIT_U : {W{1'b0}}),
                .RST_NOTIFY ((gi == 0) ? 1'b1 : 1'b0)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .load      (ld_u[gi]),
                .clear     (clr_u[gi]),
                .load_data (u_data),
                .data      (b_out[gi*W +: W]),
                .notify    (b_out_notify[gi])
            );
        end
    endgenerate

    out_port_reg #(
        .W          (W),
        .RST_DATA   ({W{1'b0}}),
        .RST_NOTIFY (1'b0)
    ) u_out2 (
        .clk       (clk),
        .rst       (rst),
        .load      (ld_s),
        .clear     (clr_s),
        .load_data (val_s_q),
        .data      (b_out2),
        .notify    (b_out2_notify)
    );

endmodule

// File: doc/section_writer_n.md
SECTION_WRITER_N -- requirements
Module: section_writer_n

Interface
REQ-001 SHALL have parameter W, default 32, meaning data width of all output ports in bits.
REQ-002 SHALL have parameter N, default 2, meaning number of unsigned output channels (legal values 1..16).
REQ-003 SHALL have parameter STEP, default 1, meaning the amount added to the unsigned value and subtracted from the signed value per transfer.
REQ-004 SHALL have parameter INIT_U, default 13, meaning the unsigned value at reset.
REQ-005 SHALL have parameter INIT_S, default -7, meaning the signed value at reset.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port b_out, output, N*W bits, unsigned data; channel k occupies bits [k*W +: W].
REQ-009 SHALL have port b_out_sync, input, N bits, per-channel consumer ready.
REQ-010 SHALL have port b_out_notify, output, N bits, per-channel data valid.
REQ-011 SHALL have port b_out2, output, W bits, signed data.
REQ-012 SHALL have port b_out2_sync, input, 1 bit, consumer ready for b_out2.
REQ-013 SHALL have port b_out2_notify, output, 1 bit, data valid for b_out2.

Function
REQ-014 SHALL implement a two-state section FSM: SECTION_A (write unsigned value to channels in round-robin order), SECTION_B (write signed value).
REQ-015 SHALL hold internal registers: val_u (W bits, unsigned), val_s (W bits, two's complement), ch (channel index, $clog2(N) bits, minimum 1 bit).
REQ-016 SHALL count a transfer only on a cycle where notify and the matching sync are both high; sync on any non-notified port SHALL be ignored.
REQ-017 SHALL keep at most one notify bit high at any time, across b_out_notify and b_out2_notify.
REQ-018 SHALL hold data and notify stable while notify is high and no transfer occurs; a stall of any length SHALL be allowed.
REQ-019 SECTION_A, on transfer when ch<N-1: next cycle val_u=val_u+STEP (mod 2^W), ch=ch+1, notify one-hot at the new ch carrying the new val_u.
REQ-020 SECTION_A, on transfer when ch=N-1: next cycle val_u=val_u+STEP, all b_out_notify=0, b_out2=val_s, b_out2_notify=1, enter SECTION_B.
REQ-021 SECTION_B, on transfer: next cycle val_s=val_s-STEP (wraps two's complement), b_out2_notify=0, ch=0, b_out_notify[0]=1 carrying the current val_u, enter SECTION_A.
REQ-022 SHALL sustain one transfer per cycle when sync is held high; there SHALL be no idle cycle between transfers.
REQ-023 With N=1, the block SHALL alternate strictly: channel 0, b_out2, channel 0, and so on.
REQ-024 SHALL leave the data of non-notified channels unchanged: each channel holds its last written value, and holds 0 if never written.

Reset
REQ-025 When rst is high at a clock edge, the next state SHALL be: section=SECTION_A, val_u=INIT_U, val_s=INIT_S, ch=0, b_out channel 0=INIT_U, other channels=0, b_out_notify=1 on bit 0 only, b_out2=0, b_out2_notify=0.
REQ-026 Reset SHALL override any simultaneous transfer, including reset asserted mid-stall in either section.

Structure
REQ-027 A shared package section_writer_n_types SHALL hold the SECTIONS enum (SECTION_A, SECTION_B).
REQ-028 A single sub-module out_port_reg (data plus notify register with load and clear controls) SHALL be instantiated N+1 times.

Verification
REQ-029 Defaults, all sync held at 1 after reset: transfers in order SHALL be b_out[0]=13, b_out[1]=14, b_out2=-7, b_out[0]=15, b_out[1]=16, b_out2=-8, on consecutive cycles.
REQ-030 b_out_sync=0 for 10 cycles after reset: b_out_notify SHALL stay 2'b01 with channel 0 data=13 and the FSM SHALL not advance; when sync rises, the transfer SHALL occur on that cycle.
REQ-031 b_out_sync=2'b10 while channel 0 is notified: no transfer SHALL occur and ch SHALL remain 0.
REQ-032 INIT_U=32'hFFFF_FFFF: channel 0 SHALL carry FFFF_FFFF, then channel 1 SHALL carry 0 (wrap).
REQ-033 rst pulsed while b_out2_notify=1 and b_out2_sync=1: the next cycle SHALL show exactly the REQ-025 state, with no b_out2 transfer counted.
REQ-034 N=1, W=8, INIT_S=-128: the second b_out2 transfer SHALL carry 127 (signed wrap).
